// File: rtl/xpb_pkg.sv
// Shared definitions for the xpb accumulator.
//   WORD_W  : width of one incoming xpb term
//   GUARD_W : headroom bits, enough for 2^GUARD_W terms without loss
//   N_SEG   : number of carry-propagate segments in the resolve phase
//   ACC_W   : accumulator width (term plus headroom)
//   SEG_W   : width of one resolve segment
//   state_t : accumulator FSM states
package xpb_pkg;

  localparam int WORD_W  = 1024;
  localparam int GUARD_W = 8;
  localparam int N_SEG   = 8;
  localparam int ACC_W   = WORD_W + GUARD_W;
  localparam int SEG_W   = ACC_W / N_SEG;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    RESOLVE,
    DONE
  } state_t;

endpackage

// File: rtl/xpb_csa.sv
// Carry-save 3:2 compressor: reduces three operands to a sum/carry pair
// with no carry propagation. Purely combinational.
//   a, b, c : operands
//   sum     : bitwise sum a^b^c
//   carry   : majority bits shifted up one place, top bit dropped
module xpb_csa
  import xpb_pkg::*;
#(
  parameter int W = ACC_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] c,
  output logic [W-1:0] sum,
  output logic [W-1:0] carry
);

  logic [W-1:0] maj;

  assign maj   = (a & b) | (a & c) | (b & c);
  assign sum   = a ^ b ^ c;
  assign carry = maj << 1;

endmodule

// File: rtl/xpb_accum.sv
// Wide accumulator for xpb terms. Terms are folded into a carry-save
// pair (S,C) at one per cycle; on the last term the pair is resolved
// into a binary sum by a segmented ripple adder, one segment per cycle.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : term handshake; in_data is the term, in_last
//                         marks the final term of a reduction
//   out_valid/out_ready : result handshake
//   out_data            : resolved sum (WORD_W+GUARD_W bits)
//   out_count           : terms accumulated, saturating at 2^GUARD_W
//   out_ovf             : sticky, set if more than 2^GUARD_W terms arrived
module xpb_accum
  import xpb_pkg::state_t;
  import xpb_pkg::IDLE;
  import xpb_pkg::ACCUM;
  import xpb_pkg::RESOLVE;
  import xpb_pkg::DONE;
#(
  parameter int WORD_W  = xpb_pkg::WORD_W,
  parameter int GUARD_W = xpb_pkg::GUARD_W,
  parameter int N_SEG   = xpb_pkg::N_SEG
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WORD_W-1:0]          in_data,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WORD_W+GUARD_W-1:0]  out_data,
  output logic [GUARD_W:0]           out_count,
  output logic                       out_ovf
);

  localparam int ACC_W     = WORD_W + GUARD_W;
  localparam int SEG_W     = ACC_W / N_SEG;
  localparam int SEG_IDX_W = (N_SEG > 1) ? $clog2(N_SEG) : 1;

  localparam logic [SEG_IDX_W-1:0] LAST_SEG  = SEG_IDX_W'(N_SEG - 1);
  localparam logic [GUARD_W:0]     COUNT_MAX = {1'b1, {GUARD_W{1'b0}}};

  state_t                 state_q;
  logic [ACC_W-1:0]       s_q, c_q, r_q;
  logic [GUARD_W:0]       count_q;
  logic                   ovf_q;
  logic [SEG_IDX_W-1:0]   seg_idx_q;
  logic                   seg_carry_q;
  logic                   in_ready_q;
  logic                   out_valid_q;

  logic                   accept;
  logic [ACC_W-1:0]       term;
  logic [ACC_W-1:0]       csa_sum, csa_carry;
  logic [SEG_W-1:0]       s_seg, c_seg, r_seg;
  logic                   seg_cout;

  assign accept = in_valid & in_ready_q;
  assign term   = {{GUARD_W{1'b0}}, in_data};

  xpb_csa #(
    .W (ACC_W)
  ) u_csa (
    .a     (s_q),
    .b     (c_q),
    .c     (term),
    .sum   (csa_sum),
    .carry (csa_carry)
  );

  // One segment of the carry-propagate resolve, selected by seg_idx_q.
  // NOTE: every signal assigned in always_comb gets a value on every path,
  // otherwise synthesis infers a latch to hold the missing case.
  always_comb begin
    s_seg = s_q[int'(seg_idx_q) * SEG_W +: SEG_W];
    c_seg = c_q[int'(seg_idx_q) * SEG_W +: SEG_W];
    {seg_cout, r_seg} = {1'b0, s_seg} + {1'b0, c_seg} + {{SEG_W{1'b0}}, seg_carry_q};
  end

  // in_ready is registered so it stays low for as long as reset is held and
  // rises on the first edge after release.
  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      s_q         <= '0;
      c_q         <= '0;
      r_q         <= '0;
      count_q     <= '0;
      ovf_q       <= 1'b0;
      seg_idx_q   <= '0;
      seg_carry_q <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            s_q <= csa_sum;
            c_q <= csa_carry;
            if (count_q != COUNT_MAX) count_q <= count_q + 1'b1;
            else                      ovf_q   <= 1'b1;
            if (in_last) begin
              state_q     <= RESOLVE;
              seg_idx_q   <= '0;
              seg_carry_q <= 1'b0;
              in_ready_q  <= 1'b0;
            end else begin
              state_q <= ACCUM;
            end
          end
        end
        RESOLVE: begin
          r_q[int'(seg_idx_q) * SEG_W +: SEG_W] <= r_seg;
          // Carry out of the top segment is meaningless and is reset on the
          // next entry to RESOLVE.
          seg_carry_q <= seg_cout;
          if (seg_idx_q == LAST_SEG) begin
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end else begin
            seg_idx_q <= seg_idx_q + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            s_q         <= '0;
            c_q         <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = r_q;
  assign out_count = count_q;
  assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_xpb_accum.sv
// Directed testbench for xpb_accum at default parameters.
module tb_xpb_accum;

  localparam int WORD_W  = 1024;
  localparam int GUARD_W = 8;
  localparam int N_SEG   = 8;
  localparam int ACC_W   = WORD_W + GUARD_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;
  logic              in_last;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_data;
  logic [GUARD_W:0]  out_count;
  logic              out_ovf;

  int total = 0;
  int bad   = 0;

  xpb_accum #(
    .WORD_W  (WORD_W),
    .GUARD_W (GUARD_W),
    .N_SEG   (N_SEG)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_count (out_count),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [ACC_W-1:0] obs,
                       input logic [ACC_W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got hi=%h lo=%h want hi=%h lo=%h", tag,
             obs[ACC_W-1 -: 64], obs[63:0], exp[ACC_W-1 -: 64], exp[63:0]);
    end
  endtask

  // Present one term from a negedge, wait (bounded) for in_ready, let the
  // next rising edge accept it, then drop in_valid 1 time unit later.
  task automatic send(input logic [WORD_W-1:0] d, input logic last);
    int n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("send_ready", ACC_W'(in_ready), ACC_W'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Called 1 time unit after the accepting edge; counts edges to out_valid.
  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!out_valid && cycles < 50) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  task automatic take_result();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    int                lat;
    int                stale;
    logic [WORD_W-1:0] ones;
    logic [ACC_W-1:0]  exp_two;
    logic [ACC_W-1:0]  exp_256;

    ones    = {WORD_W{1'b1}};
    exp_two = {7'b0, 1'b1, {1023{1'b1}}, 1'b0};  // 2^1025 - 2
    exp_256 = {{1024{1'b1}}, 8'h00};             // 2^1032 - 256

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b0;

    // Reset state
    #12;
    check("rst_in_ready",  ACC_W'(in_ready),  ACC_W'(0));
    check("rst_out_valid", ACC_W'(out_valid), ACC_W'(0));
    check("rst_out_data",  out_data,          ACC_W'(0));
    check("rst_out_count", ACC_W'(out_count), ACC_W'(0));
    check("rst_out_ovf",   ACC_W'(out_ovf),   ACC_W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", ACC_W'(in_ready), ACC_W'(1));

    // Single term with in_last from IDLE
    send(WORD_W'(1), 1'b1);
    check("single_no_early_valid", ACC_W'(out_valid), ACC_W'(0));
    wait_done(lat);
    check("single_latency", ACC_W'(lat),       ACC_W'(8));
    check("single_data",    out_data,          ACC_W'(1));
    check("single_count",   ACC_W'(out_count), ACC_W'(1));
    check("single_ovf",     ACC_W'(out_ovf),   ACC_W'(0));
    check("single_in_ready_done", ACC_W'(in_ready), ACC_W'(0));
    take_result();
    check("single_cleared_valid", ACC_W'(out_valid), ACC_W'(0));

    // Two all-ones terms
    send(ones, 1'b0);
    send(ones, 1'b1);
    wait_done(lat);
    check("two_latency", ACC_W'(lat),       ACC_W'(8));
    check("two_data",    out_data,          exp_two);
    check("two_count",   ACC_W'(out_count), ACC_W'(2));
    check("two_ovf",     ACC_W'(out_ovf),   ACC_W'(0));
    take_result();

    // 256 all-ones terms with random idle gaps
    for (int i = 0; i < 256; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      send(ones, (i == 255));
    end
    wait_done(lat);
    check("t256_latency", ACC_W'(lat),       ACC_W'(8));
    check("t256_data",    out_data,          exp_256);
    check("t256_count",   ACC_W'(out_count), ACC_W'(256));
    check("t256_ovf",     ACC_W'(out_ovf),   ACC_W'(0));
    take_result();

    // 257 terms of value 1: count saturates, ovf sets
    for (int i = 0; i < 257; i++) send(WORD_W'(1), (i == 256));
    wait_done(lat);
    check("ovf_data",  out_data,          ACC_W'(257));
    check("ovf_count", ACC_W'(out_count), ACC_W'(256));
    check("ovf_flag",  ACC_W'(out_ovf),   ACC_W'(1));
    take_result();
    check("ovf_cleared_flag",  ACC_W'(out_ovf),   ACC_W'(0));
    check("ovf_cleared_count", ACC_W'(out_count), ACC_W'(0));

    // Backpressure in DONE with in_valid held high
    send(WORD_W'(3), 1'b0);
    send(WORD_W'(4), 1'b1);
    wait_done(lat);
    check("bp_latency", ACC_W'(lat), ACC_W'(8));
    in_valid = 1'b1;
    in_data  = WORD_W'(9);
    in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid",    ACC_W'(out_valid), ACC_W'(1));
      check("bp_data",     out_data,          ACC_W'(7));
      check("bp_count",    ACC_W'(out_count), ACC_W'(2));
      check("bp_in_ready", ACC_W'(in_ready),  ACC_W'(0));
    end
    take_result();
    check("bp_idle_valid",    ACC_W'(out_valid), ACC_W'(0));
    check("bp_idle_in_ready", ACC_W'(in_ready),  ACC_W'(1));
    check("bp_idle_count",    ACC_W'(out_count), ACC_W'(0));
    send(WORD_W'(9), 1'b1);
    wait_done(lat);
    check("bp_next_data",  out_data,          ACC_W'(9));
    check("bp_next_count", ACC_W'(out_count), ACC_W'(1));
    take_result();

    // Reset while resolving segment 3
    send(WORD_W'(11), 1'b1);
    repeat (2) @(posedge clk);
    #1;
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid",    ACC_W'(out_valid), ACC_W'(0));
    check("mid_rst_in_ready", ACC_W'(in_ready),  ACC_W'(0));
    check("mid_rst_data",     out_data,          ACC_W'(0));
    check("mid_rst_count",    ACC_W'(out_count), ACC_W'(0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_release_ready", ACC_W'(in_ready), ACC_W'(1));
    stale = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    check("mid_rst_no_stale", ACC_W'(stale), ACC_W'(0));
    send(WORD_W'(5), 1'b1);
    wait_done(lat);
    check("mid_rst_latency", ACC_W'(lat),       ACC_W'(8));
    check("mid_rst_data5",   out_data,          ACC_W'(5));
    check("mid_rst_count1",  ACC_W'(out_count), ACC_W'(1));
    check("mid_rst_ovf0",    ACC_W'(out_ovf),   ACC_W'(0));
    take_result();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/xpb_accum.md
XPB_ACCUM -- requirements
Module: xpb_accum

Interface
REQ-001 SHALL have parameter WORD_W, default 1024, meaning the width of each incoming xpb term.
REQ-002 SHALL have parameter GUARD_W, default 8, meaning the number of headroom bits for up to 2^GUARD_W terms.
REQ-003 SHALL have parameter N_SEG, default 8, meaning the number of carry-propagate segments used in the resolve phase.
REQ-004 Port list (clock and reset first):
 clk  input  1  single clock; all state updates on the rising edge.
 rst_n  input  1  asynchronous, active-low reset.
 in_valid  input  1  in_data/in_last are valid.
 in_ready  output  1  block accepts a term.
 in_data  input  WORD_W  xpb term from the lookup stage.
 in_last  input  1  marks the final term of a reduction.
 out_valid  output  1  result is available.
 out_ready  input  1  consumer accepts the result.
 out_data  output  WORD_W+GUARD_W  resolved sum.
 out_count  output  GUARD_W+1  number of terms accumulated.
 out_ovf  output  1  more than 2^GUARD_W terms were received.

Function
REQ-005 SHALL implement FSM states IDLE, ACCUM, RESOLVE and DONE.
REQ-006 SHALL drive in_ready=1 in IDLE and ACCUM only.
REQ-007 SHALL treat a term as accepted on a clock edge where in_valid&in_ready=1.
REQ-008 Accepted term SHALL update the carry-save pair (S,C), each ACC_W=WORD_W+GUARD_W bits wide:
 S' = S^C^T;
 C' = maj(S,C,T)<<1, with bits above ACC_W discarded;
 T is in_data zero-extended.
REQ-009 State transitions on acceptance:
 IDLE, in_last=0 -> ACCUM;
 IDLE or ACCUM, in_last=1 -> RESOLVE, segment index=0, segment carry=0.
REQ-010 out_count SHALL increment per accepted term and saturate at 2^GUARD_W.
REQ-011 out_ovf SHALL set sticky when a term is accepted with count already at 2^GUARD_W.
REQ-012 RESOLVE SHALL process one segment of width ACC_W/N_SEG per cycle, least significant first:
 {carry, R_i} = S_i + C_i + carry;
 the carry out of the top segment is discarded.
REQ-013 After segment N_SEG-1 the FSM SHALL enter DONE.
 Resulting latency: out_valid rises exactly N_SEG edges after the edge accepting the last term (8 at defaults).
REQ-014 In DONE, out_valid=1, and out_data, out_count and out_ovf SHALL remain stable until out_valid&out_ready.
REQ-015 DONE with out_ready=1 -> IDLE; S, C, count and ovf SHALL be cleared on the same edge.
 in_ready is not asserted until the next cycle (no bypass).
REQ-016 in_valid SHALL be ignored in RESOLVE and DONE; no term SHALL be lost, because in_ready=0 there.
REQ-017 out_valid SHALL be 0 in every state except DONE.
REQ-018 A zero-term reduction is impossible: the first accepted term always counts, including a lone in_last=1 term accepted from IDLE.

Reset
REQ-019 rst_n=0 SHALL immediately, asynchronously, force:
 state=IDLE; S=C=R=0; count=0; ovf=0;
 in_ready=0 while reset is asserted; out_valid=0; out_data=0.
REQ-020 Reset asserted during ACCUM or RESOLVE SHALL abort the reduction with no output produced.
 The first cycle after deassertion has in_ready=1.

Structure
REQ-021 Package xpb_pkg SHALL hold WORD_W, GUARD_W, N_SEG, derived ACC_W and SEG_W, and the FSM state enum.
REQ-022 The 3:2 compressor SHALL be a sub-module xpb_csa, parameterized by width and purely combinational.
 The FSM, counters and resolve adder SHALL live in xpb_accum.

Verification
REQ-023 Single term:
 stimulus: in_data=1, in_last=1 from IDLE;
 required: out_data=1, out_count=1, out_ovf=0, out_valid 8 cycles after acceptance.
REQ-024 Two terms:
 stimulus: in_data=2^1024-1 twice, second with in_last;
 required: out_data=2^1025-2, out_count=2.
REQ-025 256 terms:
 stimulus: 256 terms of 2^1024-1 with random in_valid gaps;
 required: out_data=256*(2^1024-1), out_count=256, out_ovf=0.
REQ-026 Overflow:
 stimulus: 257 terms of value 1;
 required: out_ovf=1, out_count=256.
REQ-027 Backpressure:
 stimulus: out_ready held 0 for 5 cycles in DONE while in_valid=1;
 required: outputs stable, in_ready=0, no terms accepted, IDLE on the first out_ready=1 edge.
REQ-028 Reset mid-operation:
 stimulus: rst_n pulsed low at RESOLVE segment 3, then one term of value 5;
 required: no stale output, result 5.
